// File: rtl/sntrup_pkg.sv
// Shared constants and types for the SNTRUP757 arithmetic core.
package sntrup_pkg;

    localparam int AW = 11;
    localparam int CW = 13;
    localparam int PW = 2 * CW;

    localparam logic [CW-1:0] Q = 13'd4591;

    // floor(2^26 / 4591); with a 26-bit dividend the quotient estimate
    // is at most one short, so a single conditional subtract finishes.
    localparam int          BARRETT_SH = 26;
    localparam logic [13:0] BARRETT_M  = 14'd14617;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mod_q_reduce.sv
// Combinational exact reduction of a 26-bit value into [0, Q-1].
module mod_q_reduce
    import sntrup_pkg::*;
(
    input  logic [PW-1:0] x_i,
    output logic [CW-1:0] r_o
);

    localparam int EW = PW + 14;

    logic [EW-1:0] prod;
    logic [EW-1:0] q_est;
    logic [EW-1:0] q_mul;
    logic [EW-1:0] rem;
    logic [EW-1:0] q_ext;

    // Barrett quotient estimate, remainder, one correction step.
    always_comb begin
        q_ext = {{(EW - CW){1'b0}}, Q};
        prod  = {14'd0, x_i} * {{PW{1'b0}}, BARRETT_M};
        q_est = prod >> BARRETT_SH;
        q_mul = q_est * q_ext;
        rem   = {14'd0, x_i} - q_mul;
        r_o   = (rem >= q_ext) ? CW'(rem - q_ext) : CW'(rem);
    end

endmodule

// File: rtl/poly_mac_add.sv
// S(x) = A(x) + c*x^k*B(x) mod Q over synchronous coefficient memories.
// Four-stage pipeline: address, memory data + mask + multiply,
// reduce + add, registered write.
// Build option: POLY_MAC_DEGSCAN_EN enables the true-degree / zero scan;
// without it deg reports L-1 and zero is tied low.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, result outputs held
// S_ISSUE | presenting index n = 0..L-1, one per cycle
// S_DRAIN | 3 cycles letting the pipeline empty
// S_DONE  | one-cycle done pulse
module poly_mac_add
    import sntrup_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] degA,
    input  logic [AW-1:0] degB,
    input  logic [CW-1:0] coef,
    input  logic [AW-1:0] shift,
    output logic [AW-1:0] mem_address_oM1,
    output logic [AW-1:0] mem_address_oM2,
    input  logic [CW-1:0] mem_outputM1,
    input  logic [CW-1:0] mem_outputM2,
    output logic [AW-1:0] mem_address_iS,
    output logic [CW-1:0] mem_inputS,
    output logic          write_enable,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] deg,
    output logic          zero
);

    state_t        state_q, state_d;
    logic [AW-1:0] n_q, m2_q, n_nx;
    logic [AW-1:0] dega_q, hib_q, k_q, last_q;
    logic [CW-1:0] c_q;
    logic [1:0]    drain_q;
    logic          err_q, res_v_q;

    logic          v1_q, v2_q, we_q;
    logic [AW-1:0] n1_q, n2_q, addrs_q;
    logic [CW-1:0] a2_q, datas_q;
    logic [PW-1:0] p2_q;

    logic [AW:0]   sum_b;
    logic          ovf, start_ok;
    logic [AW-1:0] last_in;
    logic [CW-1:0] a_m, b_m, r_red, s_val;
    logic [PW-1:0] p_d;
    logic [CW:0]   s_sum;

    // Launch decode: top index L-1 and the degB+k overflow check.
    always_comb begin
        sum_b    = {1'b0, degB} + {1'b0, shift};
        ovf      = sum_b[AW];
        last_in  = (degA > sum_b[AW-1:0]) ? degA : sum_b[AW-1:0];
        start_ok = start && (state_q == S_IDLE);
        n_nx     = n_q + AW'(1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = ovf ? S_DONE : S_ISSUE;
            S_ISSUE: if (n_q == last_q) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == 2'd2) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, index counter, read addresses, drain timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            m2_q    <= '0;
            dega_q  <= '0;
            hib_q   <= '0;
            k_q     <= '0;
            last_q  <= '0;
            c_q     <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
            res_v_q <= 1'b0;
        end else begin
            if (start_ok) begin
                dega_q  <= degA;
                hib_q   <= sum_b[AW-1:0];
                k_q     <= shift;
                c_q     <= coef;
                last_q  <= last_in;
                n_q     <= '0;
                m2_q    <= '0;
                err_q   <= ovf;
                res_v_q <= 1'b0;
            end else if (state_q == S_ISSUE && n_q != last_q) begin
                n_q  <= n_nx;
                m2_q <= (n_nx >= k_q) ? n_nx - k_q : '0;
            end
            if (state_q == S_DRAIN && state_d == S_DONE) res_v_q <= 1'b1;
            drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
        end
    end

    // Masking and scaling of returned memory data.
    always_comb begin
        a_m = (n1_q <= dega_q) ? mem_outputM1 : '0;
        b_m = (n1_q >= k_q && n1_q <= hib_q) ? mem_outputM2 : '0;
        p_d = {{CW{1'b0}}, c_q} * {{CW{1'b0}}, b_m};
    end

    mod_q_reduce u_reduce (
        .x_i (p2_q),
        .r_o (r_red)
    );

    // Final modular add of A coefficient and reduced product.
    always_comb begin
        s_sum = {1'b0, a2_q} + {1'b0, r_red};
        s_val = (s_sum >= {1'b0, Q}) ? CW'(s_sum - {1'b0, Q}) : s_sum[CW-1:0];
    end

    // Data pipeline: mem-data stage, product stage, write stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            n1_q    <= '0;
            v2_q    <= 1'b0;
            n2_q    <= '0;
            a2_q    <= '0;
            p2_q    <= '0;
            we_q    <= 1'b0;
            addrs_q <= '0;
            datas_q <= '0;
        end else begin
            v1_q <= (state_q == S_ISSUE);
            n1_q <= n_q;
            v2_q <= v1_q;
            n2_q <= n1_q;
            a2_q <= a_m;
            p2_q <= p_d;
            we_q <= v2_q;
            if (v2_q) begin
                addrs_q <= n2_q;
                datas_q <= s_val;
            end
        end
    end

`ifdef POLY_MAC_DEGSCAN_EN
    logic [AW-1:0] deg_q;
    logic          nz_q;

    // Track the highest index written with a nonzero coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deg_q <= '0;
            nz_q  <= 1'b0;
        end else if (start_ok) begin
            deg_q <= '0;
            nz_q  <= 1'b0;
        end else if (v2_q && s_val != '0) begin
            deg_q <= n2_q;
            nz_q  <= 1'b1;
        end
    end

    assign deg  = deg_q;
    assign zero = res_v_q & ~nz_q;
`else
    assign deg  = res_v_q ? last_q : '0;
    assign zero = 1'b0;
`endif

    assign mem_address_oM1 = n_q;
    assign mem_address_oM2 = m2_q;
    assign mem_address_iS  = addrs_q;
    assign mem_inputS      = datas_q;
    assign write_enable    = we_q;
    assign busy            = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done            = (state_q == S_DONE);
    assign err             = err_q;

endmodule
